// File: rtl/multicycle_processor_pkg.sv
`default_nettype none
// ============================================================================
// multicycle_processor_pkg - opcodes, functs, FSM states and ALU ops
// Rev 1.0
// ============================================================================
package multicycle_processor_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6
  } alu_op_t;

  function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
    alu_op_t op;
    case (funct)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      FN_SLL:  op = ALU_SLL;
      FN_SRL:  op = ALU_SRL;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic is_legal(input logic [31:0] instr);
    logic ok;
    ok = 1'b0;
    case (instr[31:26])
      OP_RTYPE: begin
        case (instr[5:0])
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL, FN_JR: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_processor_regfile.sv
`default_nettype none
// ============================================================================
// regfile_2r1w - 2 async read / 1 sync write register file, r0 reads zero
// Rev 1.0
// ============================================================================
module regfile_2r1w #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [0:NREGS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule
`default_nettype wire

// File: rtl/multicycle_processor.sv
`default_nettype none
// ============================================================================
// multicycle_processor - multi-cycle MIPS-subset core, shared ALU, req/ack memory
// Rev 1.0
// ============================================================================
module multicycle_processor
  import multicycle_processor_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            retire,
  output logic [XLEN-1:0] pc_out,
  output logic            halted,
  output logic            illegal
);

  localparam int         AW     = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [4:0] RA_IDX = 5'd31;

  state_t          state, next_state;
  logic [31:0]     ir;
  logic [XLEN-1:0] pc, ipc, a_reg, b_reg, target, alu_out;
  logic            halted_q, illegal_q;

  logic [5:0]      op, funct;
  logic [4:0]      shamt;
  logic [AW-1:0]   rs, rt, rd;
  logic [XLEN-1:0] imm_sext, branch_off, jump_target;

  assign op          = ir[31:26];
  assign funct       = ir[5:0];
  assign shamt       = ir[10:6];
  assign rs          = ir[21 +: AW];
  assign rt          = ir[16 +: AW];
  assign rd          = ir[11 +: AW];
  assign imm_sext    = {{(XLEN-16){ir[15]}}, ir[15:0]};
  assign branch_off  = {imm_sext[XLEN-3:0], 2'b00};
  assign jump_target = {pc[XLEN-1:28], ir[25:0], 2'b00};

  logic is_jr, is_br;
  assign is_jr = (op == OP_RTYPE) && (funct == FN_JR);
  assign is_br = (op == OP_BEQ) || (op == OP_BNE);

  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;

  regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (alu_out)
  );

  // One ALU serves PC+4 in FETCH, branch target in DECODE and the operation in EXEC.
  alu_op_t         alu_op;
  logic [XLEN-1:0] alu_a, alu_b, alu_res;
  logic            alu_zero;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = alu_a + alu_b;
      ALU_SUB: alu_res = alu_a - alu_b;
      ALU_AND: alu_res = alu_a & alu_b;
      ALU_OR:  alu_res = alu_a | alu_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLL: alu_res = alu_b << shamt;
      ALU_SRL: alu_res = alu_b >> shamt;
      default: alu_res = alu_a + alu_b;
    endcase
  end

  assign alu_zero = (alu_res == '0);

  logic retire_c, set_halt, set_illegal;

  always_comb begin
    next_state  = state;
    alu_a       = a_reg;
    alu_b       = b_reg;
    alu_op      = ALU_ADD;
    rf_we       = 1'b0;
    rf_waddr    = rd;
    retire_c    = 1'b0;
    set_halt    = 1'b0;
    set_illegal = 1'b0;
    case (state)
      S_FETCH: begin
        alu_a = pc;
        alu_b = XLEN'(4);
        if (mem_ack) next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_a = pc;
        alu_b = branch_off;
        if (ir == 32'h0) begin
          next_state = S_HALT;
          set_halt   = 1'b1;
        end else if (!is_legal(ir)) begin
          next_state  = S_HALT;
          set_halt    = 1'b1;
          set_illegal = 1'b1;
        end else if (op == OP_J) begin
          next_state = S_FETCH;
          retire_c   = 1'b1;
        end else if (op == OP_JAL) begin
          next_state = S_WB;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op == OP_RTYPE)  alu_op = funct_to_alu(funct);
        else if (is_br)      alu_op = ALU_SUB;
        else                 alu_b  = imm_sext;
        if (is_br || is_jr) begin
          next_state = S_FETCH;
          retire_c   = 1'b1;
        end else if ((op == OP_LW) || (op == OP_SW)) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          if (op == OP_LW) begin
            next_state = S_WB;
          end else begin
            next_state = S_FETCH;
            retire_c   = 1'b1;
          end
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        if (op == OP_JAL)       rf_waddr = RA_IDX[AW-1:0];
        else if (op != OP_RTYPE) rf_waddr = rt;
        next_state = S_FETCH;
        retire_c   = 1'b1;
      end
      S_HALT: next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ipc       <= RESET_PC;
      ir        <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      target    <= '0;
      alu_out   <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (set_halt)    halted_q  <= 1'b1;
      if (set_illegal) illegal_q <= 1'b1;
      case (state)
        S_FETCH: begin
          if (mem_ack) begin
            ir  <= mem_rdata[31:0];
            ipc <= pc;
            pc  <= alu_res;
          end
        end
        S_DECODE: begin
          a_reg   <= rf_rdata1;
          b_reg   <= rf_rdata2;
          target  <= alu_res;
          // Holds the link address for jal until WB.
          alu_out <= pc;
          if ((op == OP_J) || (op == OP_JAL)) pc <= jump_target;
        end
        S_EXEC: begin
          alu_out <= alu_res;
          if (((op == OP_BEQ) && alu_zero) || ((op == OP_BNE) && !alu_zero)) pc <= target;
          else if (is_jr) pc <= a_reg;
        end
        S_MEM: begin
          if (mem_ack && (op == OP_LW)) alu_out <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = rst_n && ((state == S_FETCH) || (state == S_MEM));
  assign mem_we    = mem_req && (state == S_MEM) && (op == OP_SW);
  assign mem_addr  = !mem_req ? '0 :
                     (state == S_FETCH) ? {pc[XLEN-1:2], 2'b00} : {alu_out[XLEN-1:2], 2'b00};
  assign mem_wdata = mem_we ? b_reg : '0;
  assign retire    = retire_c;
  assign pc_out    = (state == S_FETCH) ? pc : ipc;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_processor.sv
`default_nettype none
// tb_multicycle_processor - directed programs on a 32-bit core and a 64-bit/16-reg core.
`timescale 1ns/1ps
module tb_multicycle_processor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- 32-bit core ----------------
  logic        rst32_n = 1'b0;
  logic        req32, we32, retire32, halted32, illegal32;
  logic        ack32 = 1'b0;
  logic [31:0] addr32, wdata32, pc32;
  logic [31:0] rdata32 = '0;
  logic [31:0] img32 [0:255];
  logic [31:0] mem32 [0:255];
  logic [31:0] rd_log [0:63];
  int          wait32 = 0, cnt32 = 0, ret32 = 0, nrd32 = 0;
  logic        pend32 = 1'b0, hold_we = 1'b0;
  logic [31:0] hold_addr = '0, hold_wdata = '0;

  multicycle_processor u32 (
    .clk(clk), .rst_n(rst32_n),
    .mem_req(req32), .mem_we(we32), .mem_addr(addr32), .mem_wdata(wdata32),
    .mem_rdata(rdata32), .mem_ack(ack32),
    .retire(retire32), .pc_out(pc32), .halted(halted32), .illegal(illegal32)
  );

  always @(posedge clk) begin
    if (!rst32_n) begin
      mem32 = img32;
      cnt32 = 0; ret32 = 0; nrd32 = 0;
    end else begin
      if (retire32) ret32++;
      if (req32 && ack32) begin
        if (we32) mem32[addr32[9:2]] = wdata32;
        else if (nrd32 < 64) begin rd_log[nrd32] = addr32; nrd32++; end
        cnt32 = 0;
      end else if (req32) begin
        cnt32++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst32_n) begin
      pend32 = 1'b0; ack32 = 1'b0; rdata32 = '0;
    end else begin
      if (req32 && pend32) begin
        check_eq("hold_addr",  64'(addr32),  64'(hold_addr));
        check_eq("hold_we",    64'(we32),    64'(hold_we));
        check_eq("hold_wdata", 64'(wdata32), 64'(hold_wdata));
      end
      ack32      = req32 && (cnt32 >= wait32);
      rdata32    = ack32 ? mem32[addr32[9:2]] : 32'h0;
      pend32     = req32 && !ack32;
      hold_addr  = addr32;
      hold_we    = we32;
      hold_wdata = wdata32;
    end
  end

  // ---------------- 64-bit, 16-register core ----------------
  logic        rst64_n = 1'b0;
  logic        req64, we64, retire64, halted64, illegal64;
  logic        ack64 = 1'b0;
  logic [63:0] addr64, wdata64, pc64;
  logic [63:0] rdata64 = '0;
  logic [63:0] img64 [0:255];
  logic [63:0] mem64 [0:255];
  int          cnt64 = 0, ret64 = 0;

  multicycle_processor #(.XLEN(64), .NREGS(16)) u64 (
    .clk(clk), .rst_n(rst64_n),
    .mem_req(req64), .mem_we(we64), .mem_addr(addr64), .mem_wdata(wdata64),
    .mem_rdata(rdata64), .mem_ack(ack64),
    .retire(retire64), .pc_out(pc64), .halted(halted64), .illegal(illegal64)
  );

  always @(posedge clk) begin
    if (!rst64_n) begin
      mem64 = img64;
      cnt64 = 0; ret64 = 0;
    end else begin
      if (retire64) ret64++;
      if (req64 && ack64) begin
        if (we64) mem64[addr64[9:2]] = wdata64;
        cnt64 = 0;
      end else if (req64) begin
        cnt64++;
      end
    end
  end

  always @(negedge clk) begin
    ack64   = rst64_n && req64;
    rdata64 = ack64 ? mem64[addr64[9:2]] : 64'h0;
  end

  // ---------------- helpers ----------------
  task automatic clear_img32();
    foreach (img32[i]) img32[i] = 32'h0;
  endtask

  task automatic reset32();
    rst32_n = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk);
    #2 rst32_n = 1'b1;
  endtask

  task automatic run32(input int max, output int cyc);
    cyc = 0;
    while (halted32 !== 1'b1 && cyc < max) begin
      @(posedge clk); #1; cyc++;
    end
    check_eq("halt_reached", 64'(halted32), 64'd1);
  endtask

  int cyc;
  int found;

  initial begin
    // Test 1: addi/addi/add/halt, zero-wait; reset values first
    wait32 = 0;
    clear_img32();
    img32[0] = 32'h2001_0005;
    img32[1] = 32'h2002_FFFD;
    img32[2] = 32'h0022_1820;
    rst32_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_mem_req",   64'(req32),     64'd0);
    check_eq("rst_mem_we",    64'(we32),      64'd0);
    check_eq("rst_mem_addr",  64'(addr32),    64'd0);
    check_eq("rst_mem_wdata", 64'(wdata32),   64'd0);
    check_eq("rst_retire",    64'(retire32),  64'd0);
    check_eq("rst_halted",    64'(halted32),  64'd0);
    check_eq("rst_illegal",   64'(illegal32), 64'd0);
    reset32();
    run32(200, cyc);
    check_eq("t1_halt_cycle", 64'(cyc),       64'd14);
    check_eq("t1_retires",    64'(ret32),     64'd3);
    check_eq("t1_illegal",    64'(illegal32), 64'd0);
    check_eq("t1_pc_out",     64'(pc32),      64'h0C);

    // Test 2: sw/lw with 3 wait cycles; misaligned store offset 0x107
    wait32 = 3;
    clear_img32();
    img32[0]  = 32'h2001_0005;
    img32[1]  = 32'h2002_FFFD;
    img32[2]  = 32'h0022_1820;
    img32[3]  = 32'hAC03_0100;
    img32[4]  = 32'h8C04_0100;
    img32[5]  = 32'hAC04_0107;
    img32[64] = 32'hDEAD_BEEF;
    reset32();
    run32(400, cyc);
    check_eq("t2_sw_r3",      64'(mem32[64]), 64'd2);
    check_eq("t2_lw_sw_r4",   64'(mem32[65]), 64'd2);
    check_eq("t2_halt_cycle", 64'(cyc),       64'd57);
    check_eq("t2_retires",    64'(ret32),     64'd6);

    // Test 3: beq taken, bne not taken
    wait32 = 0;
    clear_img32();
    img32[0]  = 32'h2001_0007;
    img32[1]  = 32'h1021_0002;
    img32[2]  = 32'h2005_0001;
    img32[3]  = 32'h2005_0002;
    img32[4]  = 32'h1421_0002;
    img32[5]  = 32'h2006_0009;
    img32[6]  = 32'hAC05_0100;
    img32[7]  = 32'hAC06_0104;
    img32[64] = 32'hDEAD_0000;
    reset32();
    run32(200, cyc);
    check_eq("t3_beq_target", 64'(rd_log[2]), 64'h10);
    check_eq("t3_bne_fall",   64'(rd_log[3]), 64'h14);
    check_eq("t3_skipped_r5", 64'(mem32[64]), 64'd0);
    check_eq("t3_r6",         64'(mem32[65]), 64'd9);
    check_eq("t3_halt_cycle", 64'(cyc),       64'd24);
    check_eq("t3_retires",    64'(ret32),     64'd6);
    check_eq("t3_pc_out",     64'(pc32),      64'h20);

    // Test 4: j, jal 0x40 from 0x10, jr r31 back to 0x14
    clear_img32();
    img32[0]  = 32'h2007_0003;
    img32[1]  = 32'h0800_0004;
    img32[4]  = 32'h0C00_0010;
    img32[5]  = 32'hAC1F_0100;
    img32[16] = 32'h03E0_0008;
    reset32();
    run32(200, cyc);
    check_eq("t4_j_target",   64'(rd_log[2]), 64'h10);
    check_eq("t4_jal_target", 64'(rd_log[3]), 64'h40);
    check_eq("t4_jr_return",  64'(rd_log[4]), 64'h14);
    check_eq("t4_r31_link",   64'(mem32[64]), 64'h14);
    check_eq("t4_retires",    64'(ret32),     64'd5);

    // Test 5: illegal opcode 3Fh, then reset in the middle of a MEM wait
    clear_img32();
    img32[0] = 32'h2001_0001;
    img32[1] = 32'hFC00_0000;
    reset32();
    run32(200, cyc);
    check_eq("t5_illegal",    64'(illegal32), 64'd1);
    check_eq("t5_retires",    64'(ret32),     64'd1);
    check_eq("t5_halt_cycle", 64'(cyc),       64'd6);
    check_eq("t5_pc_out",     64'(pc32),      64'h4);

    wait32 = 3;
    clear_img32();
    img32[0] = 32'h8C01_0100;
    reset32();
    #1;
    check_eq("t5_clr_halted",  64'(halted32),  64'd0);
    check_eq("t5_clr_illegal", 64'(illegal32), 64'd0);
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(posedge clk); #1;
      if (req32 && addr32 == 32'h100) found = 1;
    end
    check_eq("t5_mem_phase", 64'(found), 64'd1);
    #2 rst32_n = 1'b0;
    #1;
    check_eq("t5_rst_req",  64'(req32),  64'd0);
    check_eq("t5_rst_addr", 64'(addr32), 64'd0);
    @(posedge clk);
    #2 rst32_n = 1'b1;
    #1;
    check_eq("t5_restart_req",  64'(req32),  64'd1);
    check_eq("t5_restart_addr", 64'(addr32), 64'd0);
    check_eq("t5_restart_pc",   64'(pc32),   64'd0);

    // Test 6: XLEN=64, NREGS=16: sign-extension, srl, register index aliasing
    foreach (img64[i]) img64[i] = 64'h0;
    img64[0] = 64'h2001_FFFF;
    img64[1] = 64'h0001_1102;
    img64[2] = 64'hAC01_0100;
    img64[3] = 64'hAC02_0108;
    img64[4] = 64'h2011_0005;
    img64[5] = 64'hAC01_0110;
    rst64_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst64_n = 1'b1;
    cyc = 0;
    while (halted64 !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    check_eq("t6_halt_reached", 64'(halted64), 64'd1);
    check_eq("t6_r1_ones",      mem64[64],     64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("t6_r2_srl",       mem64[66],     64'h0FFF_FFFF_FFFF_FFFF);
    check_eq("t6_r17_alias",    mem64[68],     64'd5);
    check_eq("t6_retires",      64'(ret64),    64'd6);
    check_eq("t6_illegal",      64'(illegal64), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
